regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port integer register file for the LEGv8 datapath. Generalises the single-write/dual-read file.
//  Adds parametrised width, depth and read-port count, and two write ports (ALU + memory writeback).
//  Adds an asynchronous reset that reloads the power-on contents, and a per-register busy scoreboard.
//  The scoreboard tracks outstanding load destinations for hazard detection.
//  Sits in decode: read ports feed operand latches; write ports are driven from the writeback stage.
// PARAMETERS
//  DATA_W    64  register width in bits
//  ADDR_W    5   address width; NREG = 2**ADDR_W registers
//  NRD       3   number of read ports (>=1)
//  ZERO_REG  31  index of hardwired-zero register (XZR)
//  INIT_IDX  1   1: reset value of reg i is i (XZR=0); 0: all registers reset to 0
// PORTS
//  clk        in   1              clock, rising edge
//  reset_n    in   1              asynchronous active-low reset
//  ra         in   NRD*ADDR_W     read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd         out  NRD*DATA_W     read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy    out  NRD            busy flag of register addressed by ra[k]
//  we0        in   1              write enable, port 0 (ALU writeback)
//  wa0        in   ADDR_W         write address, port 0
//  wd0        in   DATA_W         write data, port 0
//  we1        in   1              write enable, port 1 (load writeback)
//  wa1        in   ADDR_W         write address, port 1
//  wd1        in   DATA_W         write data, port 1
//  set_busy   in   1              mark register set_addr busy (load issued)
//  set_addr   in   ADDR_W         register to mark busy
//  busy_vec   out  NREG           full scoreboard, bit i = register i busy
// BEHAVIOUR
//  Reset (reset_n=0, async): reg i <= (INIT_IDX ? i : 0), reg ZERO_REG <= 0, all busy <= 0.
//   While reset_n=0, writes and set_busy are ignored; rd reflects reset contents.
//  Read: combinational, 0-cycle latency; rd[k] = file[ra[k]]; ra[k]==ZERO_REG always yields 0.
//  Write: registered on posedge clk; visible on rd the cycle after.
//   Writes to ZERO_REG are dropped.
//   we0 and we1 to the same address in the same cycle: port 1 wins, port 0 is discarded.
//  Scoreboard, per posedge:
//   Busy bit of an address is cleared when that address is written by either port (we && wa==addr).
//   set_busy sets bit set_addr.
//   Set and clear of the same address in the same cycle: set wins, bit stays 1 (new load issued).
//   set_busy with set_addr==ZERO_REG is ignored; busy_vec[ZERO_REG] is constant 0.
//   rd_busy[k] = busy_vec[ra[k]].
//  Reset mid-operation: all pending writes and busy bits are lost; there is no partial update.
//  Out-of-range NREG does not arise: NREG = 2**ADDR_W exactly.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through forwarding.
//   If a read address matches an active same-cycle write (port 1 priority over port 0, never ZERO_REG),
//   rd[k] = the write data and rd_busy[k] = 0, unless set_busy targets the same address.
//  REGFILE_BYPASS_EN undefined: rd and rd_busy show registered state only.
//   Decode must stall one cycle on a read-after-write to the same address.
// STRUCTURE
//  regfile_pkg: word_t (logic [DATA_W-1:0]), reg_addr_t, XZR constant (31), function init_val(idx).
//  One sub-module: regfile_scoreboard. It holds the NREG busy flops, set/clear priority and the async reset.
//   It exposes busy_vec. Storage array and read muxing stay in regfile_mp.
// TESTING
//  Reset pulse mid-cycle, no writes -> ra=5,17,31 read 5,17,0; busy_vec=0.
//  we0=1 wa0=3 wd0=0xAAAA -> next cycle rd(ra=3)=0xAAAA. Same with wa0=31 -> rd(ra=31) stays 0.
//  we0 and we1 both to wa=7, wd0=1, wd1=2 -> reg 7 = 2.
//  set_busy addr=9 -> busy_vec[9]=1; later we1 wa1=9 -> bit clears next cycle.
//   set_busy=9 with we1 wa1=9 in the same cycle -> bit stays 1.
//  Bypass build: we1 wa1=4 wd1=0x55 with ra=4 same cycle -> rd=0x55, rd_busy=0.
//   Non-bypass build: same stimulus -> rd=old value 4.
//  Assert reset_n low with busy bits set and writes in flight -> contents and scoreboard return to reset values immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, the XZR index and the power-on contents for the LEGv8 register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;
    localparam int XZR        = 31;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    function automatic word_t init_val(input int idx, input bit init_idx, input int zero_reg);
        return (init_idx && idx != zero_reg) ? word_t'(idx) : '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags tracking outstanding load destinations; set beats clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = XZR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_busy,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr0,
    input  logic [ADDR_W-1:0]    clr_addr0,
    input  logic                 clr1,
    input  logic [ADDR_W-1:0]    clr_addr1,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (clr0 && clr_addr0 == ADDR_W'(i)) busy_d[i] = 1'b0;
            if (clr1 && clr_addr1 == ADDR_W'(i)) busy_d[i] = 1'b0;
            // A new load to a register being written back keeps it busy.
            if (set_busy && set_addr == ADDR_W'(i) && i != ZERO_REG) busy_d[i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port LEGv8 register file: NRD combinational reads, ALU and load write ports, busy scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 3,
    parameter int ZERO_REG = XZR,
    parameter int INIT_IDX = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  set_busy,
    input  logic [ADDR_W-1:0]     set_addr,
    output logic [2**ADDR_W-1:0]  busy_vec
);

    localparam int                NREG  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    // Port 1 is applied last so it overrides port 0 on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (we0 && wa0 != ZADDR) mem_d[wa0] = wd0;
        if (we1 && wa1 != ZADDR) mem_d[wa1] = wd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                mem_q[i] <= DATA_W'(init_val(i, INIT_IDX != 0, ZERO_REG));
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_busy  (set_busy),
        .set_addr  (set_addr),
        .clr0      (we0),
        .clr_addr0 (wa0),
        .clr1      (we1),
        .clr_addr1 (wa1),
        .busy_vec  (busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;
        logic              busy;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            word = (addr == ZADDR) ? '0 : mem_q[addr];
            busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarded data is complete unless a new load claims the register this cycle.
            if (reset_n && addr != ZADDR) begin
                if (we1 && wa1 == addr) begin
                    word = wd1;
                    busy = set_busy && set_addr == addr;
                end else if (we0 && wa0 == addr) begin
                    word = wd0;
                    busy = set_busy && set_addr == addr;
                end
            end
`endif
        end

        assign rd[k*DATA_W +: DATA_W] = word;
        assign rd_busy[k]             = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based register/scoreboard model.
module tb_regfile_mp;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rd_busy;
    logic              we0, we1, set_busy;
    logic [AW-1:0]     wa0, wa1, set_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [NREG-1:0]   busy_vec;

    logic [DW-1:0] m [NREG];
    bit            b [NREG];

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m[i] = (i == 31) ? '0 : DW'(i);
            b[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (we0 && wa0 != 5'd31) m[wa0] = wd0;
        if (we1 && wa1 != 5'd31) m[wa1] = wd1;
        if (we0) b[wa0] = 1'b0;
        if (we1) b[wa1] = 1'b0;
        if (set_busy && set_addr != 5'd31) b[set_addr] = 1'b1;
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return m[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (a != 5'd31 && ((we1 && wa1 == a) || (we0 && wa0 == a)))
            return set_busy && set_addr == a;
`endif
        return b[a];
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rd%0d", k), rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
            check($sformatf("rd_busy%0d", k), DW'(rd_busy[k]), DW'(exp_busy(ra[k*AW +: AW])));
        end
        check("busy_vec", DW'(busy_vec), DW'(exp_vec()));
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        set_busy = 1'b0; set_addr = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 5) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        reset_n = 1'b1;
        idle();
        set_ra(5, 17, 31);

        // Mid-cycle reset pulse with no writes.
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_r5", rd[0*DW +: DW], 64'd5);
        check("rst_r17", rd[1*DW +: DW], 64'd17);
        check("rst_r31", rd[2*DW +: DW], 64'd0);
        check("rst_busy", DW'(busy_vec), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hAAAA; set_ra(3, 7, 9);
        step();
        idle(); #1;
        check("wr3", rd[0*DW +: DW], 64'hAAAA);

        we0 = 1'b1; wa0 = 5'd31; wd0 = 64'hDEAD; set_ra(31, 3, 7);
        step();
        idle(); #1;
        check("wr_xzr", rd[0*DW +: DW], 64'd0);

        we0 = 1'b1; wa0 = 5'd7; wd0 = 64'd1;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 64'd2; set_ra(7, 3, 31);
        step();
        idle(); #1;
        check("dual_wr7", rd[0*DW +: DW], 64'd2);

        set_busy = 1'b1; set_addr = 5'd9; set_ra(9, 7, 3);
        step();
        idle(); #1;
        check("busy9_set", DW'(busy_vec[9]), 64'd1);
        check("rd_busy9", DW'(rd_busy[0]), 64'd1);

        we1 = 1'b1; wa1 = 5'd9; wd1 = 64'd99;
        step();
        idle(); #1;
        check("busy9_clr", DW'(busy_vec[9]), 64'd0);

        set_busy = 1'b1; set_addr = 5'd9; we1 = 1'b1; wa1 = 5'd9; wd1 = 64'd100;
        step();
        idle(); #1;
        check("busy9_setwins", DW'(busy_vec[9]), 64'd1);

        set_busy = 1'b1; set_addr = 5'd31;
        step();
        idle(); #1;
        check("busy_xzr", DW'(busy_vec[31]), 64'd0);

        we1 = 1'b1; wa1 = 5'd4; wd1 = 64'h55; set_ra(4, 9, 31);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd4", rd[0*DW +: DW], 64'h55);
`else
        check("bypass_rd4", rd[0*DW +: DW], 64'd4);
`endif
        check("bypass_busy4", DW'(rd_busy[0]), 64'd0);
        step();
        idle();

        // Reset while busy bits are set and writes are in flight.
        set_busy = 1'b1; set_addr = 5'd12;
        step();
        set_addr = 5'd13;
        step();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'h1234;
        we1 = 1'b1; wa1 = 5'd17; wd1 = 64'h5678;
        set_busy = 1'b1; set_addr = 5'd20; set_ra(5, 17, 12);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_r5", rd[0*DW +: DW], 64'd5);
        check("midrst_r17", rd[1*DW +: DW], 64'd17);
        check("midrst_r12", rd[2*DW +: DW], 64'd12);
        check("midrst_busy", DW'(busy_vec), 64'd0);
        @(posedge clk); #1;
        check("rst_hold_r5", rd[0*DW +: DW], 64'd5);
        check("rst_hold_r17", rd[1*DW +: DW], 64'd17);
        check("rst_hold_busy", DW'(busy_vec), 64'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            wa0 = rand_addr();
            wd0 = {$urandom, $urandom};
            we1 = 1'($urandom_range(0, 1));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : rand_addr();
            wd1 = {$urandom, $urandom};
            set_busy = 1'($urandom_range(0, 1));
            set_addr = ($urandom_range(0, 3) == 0) ? wa1 : rand_addr();
            set_ra(rand_addr(), rand_addr(), AW'($urandom_range(0, 31)));
            step();
        end

        idle();
        #1;
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
